mux5_rr_arbiter: RTL and testbench

- Five-requester round-robin arbiter that shares one n-bit result path between five producers.
- It sequences the 3-bit select of the downstream 5:1 mux: 000..011 pick sources 1..4, 1xx picks source 5.
- It captures the winning requester's data into a registered output stage with a valid/ready handshake toward the consumer.
- Used wherever several units compete for a shared bus, e.g. writeback source sharing.

---
 rtl/mux5_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux5_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux5_rr_arbiter.sv
// rtl/mux5_rr_arbiter.sv - five-source round-robin arbiter with registered output stage
//
// Purpose:
//    Shares one n-bit result path between five producers. Each cycle in
//    which the output stage can take data, the highest-priority requester
//    is captured into f, its source code is captured into s, and ack pulses
//    for one cycle on the winner's bit. The s code drives the select of a
//    downstream 5:1 mux: 000..011 are sources 1..4, 100 is source 5.
//
// Optional feature:
//    MUX5_ARB_FIXED_PRIO_EN  defined   -> fixed priority, source 1 highest.
//                            undefined -> round-robin, pointer advances past
//                                         each winner.
//
// Ports:
//    clk        in   rising-edge clock
//    rst        in   asynchronous active-high reset
//    req[4:0]   in   request level, bit k is source k+1
//    w1..w5     in   source data, n bits each
//    ack[4:0]   out  one-cycle capture pulse, bit k is source k+1
//    out_valid  out  output register holds a transfer
//    out_ready  in   consumer accepts the transfer this cycle
//    f          out  captured data
//    s          out  encoded source of f (000..100)

module mux5_rr_arbiter #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   req,
   input  logic [n-1:0] w1,
   input  logic [n-1:0] w2,
   input  logic [n-1:0] w3,
   input  logic [n-1:0] w4,
   input  logic [n-1:0] w5,
   output logic [4:0]   ack,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] f,
   output logic [2:0]   s
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t       state;
   logic [2:0]   start;
   logic [2:0]   win_idx;
   logic         win_found;
   logic         capture;
   logic [n-1:0] win_data;

`ifdef MUX5_ARB_FIXED_PRIO_EN
   // Search always begins at source 1.
   assign start = 3'd0;
`else
   // Index (0..4) of the source that has first claim on the next capture.
   logic [2:0] ptr;
   assign start = ptr;
`endif

   // Rotating search: visit start, start+1, ... wrapping modulo 5, and keep
   // the first requesting source found.
   always_comb begin : search
      logic [3:0] sum;
      logic [2:0] idx;
      win_found = 1'b0;
      win_idx   = 3'd0;
      sum       = 4'd0;
      idx       = 3'd0;
      for (int i = 0; i < 5; i++) begin
         sum = {1'b0, start} + 4'(i);
         idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      win_data = w1;
      case (win_idx)
         3'd0:    win_data = w1;
         3'd1:    win_data = w2;
         3'd2:    win_data = w3;
         3'd3:    win_data = w4;
         3'd4:    win_data = w5;
         default: win_data = w1;
      endcase
   end

   // A capture may overlap the drain of the held transfer, giving one
   // transfer per cycle while out_ready stays high.
   assign capture = win_found && ((state == IDLE) || out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         f         <= '0;
         s         <= 3'd0;
         ack       <= 5'd0;
`ifndef MUX5_ARB_FIXED_PRIO_EN
         ptr       <= 3'd0;
`endif
      end else begin
         ack <= 5'd0;
         if (capture) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            f         <= win_data;
            s         <= win_idx;
            ack       <= 5'b00001 << win_idx;
`ifndef MUX5_ARB_FIXED_PRIO_EN
            ptr       <= (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
`endif
         end else if ((state == HOLD) && out_ready) begin
            // Drained with nothing waiting; f and s keep their last value.
            state     <= IDLE;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// tb/tb_mux5_rr_arbiter.sv - self-checking bench for mux5_rr_arbiter

module tb_mux5_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req;
   logic [3:0] w [5];
   logic [4:0] ack;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] f;
   logic [2:0] s;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int m_valid, m_f, m_s, m_ack, m_ptr;

   typedef struct {
      logic [4:0] req;
      logic       rdy;
      logic [3:0] wv [5];
      int         e_valid;
      int         e_f;
      int         e_s;
      int         e_ack;
   } vec_t;

   vec_t vecs [11];

   mux5_rr_arbiter #(.n(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .w1        (w[0]),
      .w2        (w[1]),
      .w3        (w[2]),
      .w4        (w[3]),
      .w5        (w[4]),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f         (f),
      .s         (s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input int v, input int ff, input int ss, input int aa);
      chk({tag, ".out_valid"}, int'(out_valid), v);
      chk({tag, ".f"}, int'(f), ff);
      chk({tag, ".s"}, int'(s), ss);
      chk({tag, ".ack"}, int'(ack), aa);
   endtask

   task automatic model_reset();
      m_valid = 0; m_f = 0; m_s = 0; m_ack = 0; m_ptr = 0;
   endtask

   // Applies the arbitration rules to the inputs present before the edge.
   task automatic model_update();
      int j;
      bit done;
      done = 0;
      if (req != 5'd0 && (m_valid == 0 || out_ready)) begin
         for (int k = 0; k < 5; k++) begin
            j = (m_ptr + k) % 5;
            if (!done && req[j]) begin
               done    = 1;
               m_f     = int'(w[j]);
               m_s     = j;
               m_ack   = 1 << j;
               m_valid = 1;
`ifndef MUX5_ARB_FIXED_PRIO_EN
               m_ptr   = (j + 1) % 5;
`endif
            end
         end
      end else begin
         m_ack = 0;
         if (m_valid != 0 && out_ready) m_valid = 0;
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 5'd0;
      out_ready = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_w(input int a, input int b, input int c, input int d, input int e);
      w[0] = 4'(a); w[1] = 4'(b); w[2] = 4'(c); w[3] = 4'(d); w[4] = 4'(e);
   endtask

   task automatic add_vec(input int i, input logic [4:0] r, input logic rd,
                          input int ev, input int ef, input int es, input int ea);
      vecs[i].req = r;
      vecs[i].rdy = rd;
      vecs[i].wv[0] = 4'h1; vecs[i].wv[1] = 4'h2; vecs[i].wv[2] = 4'h3;
      vecs[i].wv[3] = 4'h4; vecs[i].wv[4] = 4'h5;
      vecs[i].e_valid = ev; vecs[i].e_f = ef; vecs[i].e_s = es; vecs[i].e_ack = ea;
   endtask

   initial begin
      rst = 1'b1;
      req = 5'd0;
      out_ready = 1'b0;
      set_w(0, 0, 0, 0, 0);
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      chk_out("reset", 0, 0, 0, 0);
      rst = 1'b0;
      step();
      chk_out("idle_after_reset", 0, 0, 0, 0);

`ifdef MUX5_ARB_FIXED_PRIO_EN
      set_w(1, 2, 3, 4, 5);
      req = 5'b11111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out($sformatf("fixed[%0d]", i), 1, 1, 0, 1);
      end
`else
      // Round-robin fairness from reset pointer
      set_w(1, 2, 3, 4, 5);
      req = 5'b11111; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk_out($sformatf("rr[%0d]", i), 1, (i % 5) + 1, i % 5, 1 << (i % 5));
      end
`endif

      // Single source, held request repeats every cycle
      do_reset();
      set_w(1, 2, 4'hA, 4, 5);
      req = 5'b00100; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("single[%0d]", i), 1, 4'hA, 2, 5'b00100);
      end

      // Asynchronous reset mid-cycle with a transfer pending
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      req = 5'd0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk_out($sformatf("post_rst_idle[%0d]", i), 0, 0, 0, 0);
      end

`ifndef MUX5_ARB_FIXED_PRIO_EN
      // Backpressure: capture source 5, hold, then pointer has wrapped to 1
      set_w(1, 2, 3, 4, 7);
      req = 5'b10000; out_ready = 1'b1;
      step();
      chk_out("bp_cap5", 1, 7, 4, 5'b10000);
      req = 5'b00011; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("bp_hold[%0d]", i), 1, 7, 4, 0);
      end
      out_ready = 1'b1;
      step();
      chk_out("bp_release", 1, 1, 0, 5'b00001);

      // Drain to idle, then a fresh request
      req = 5'd0;
      step();
      chk_out("drain", 0, 1, 0, 0);
      req = 5'b01000;
      step();
      chk_out("after_drain", 1, 4, 3, 5'b01000);

      // Table-driven vectors applied back to back from reset
      add_vec(0,  5'b00100, 1'b1, 1, 3, 2, 5'b00100);
      add_vec(1,  5'b00100, 1'b1, 1, 3, 2, 5'b00100);
      add_vec(2,  5'b11111, 1'b1, 1, 4, 3, 5'b01000);
      add_vec(3,  5'b11111, 1'b1, 1, 5, 4, 5'b10000);
      add_vec(4,  5'b11111, 1'b1, 1, 1, 0, 5'b00001);
      add_vec(5,  5'b11111, 1'b1, 1, 2, 1, 5'b00010);
      add_vec(6,  5'b11111, 1'b1, 1, 3, 2, 5'b00100);
      add_vec(7,  5'b00000, 1'b1, 0, 3, 2, 5'b00000);
      add_vec(8,  5'b01000, 1'b0, 1, 4, 3, 5'b01000);
      add_vec(9,  5'b10001, 1'b0, 1, 4, 3, 5'b00000);
      add_vec(10, 5'b10001, 1'b1, 1, 5, 4, 5'b10000);
      do_reset();
      for (int i = 0; i < 11; i++) begin
         req = vecs[i].req;
         out_ready = vecs[i].rdy;
         for (int k = 0; k < 5; k++) w[k] = vecs[i].wv[k];
         step();
         chk_out($sformatf("vec[%0d]", i), vecs[i].e_valid, vecs[i].e_f,
                 vecs[i].e_s, vecs[i].e_ack);
      end
`endif

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) req = 5'd0;
         out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 5; k++) w[k] = 4'($urandom_range(0, 15));
         step();
         chk_out($sformatf("rand[%0d]", i), m_valid, m_f, m_s, m_ack);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
